// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared states, step count and Booth digits for seq_multiplier.
// SEQ_MULTIPLIER_RADIX4_EN selects radix-4 Booth stepping.
package seq_mul_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_t;
`ifdef SEQ_MULTIPLIER_RADIX4_EN
    localparam int RADIX = 4;
`else
    localparam int RADIX = 2;
`endif
    function automatic int n_steps(input int w, input int radix);
        return radix == 4 ? w / 2 + 1 : w;
    endfunction
    // Radix-4 keeps two guard bits on Hi and the implicit bit -1 below Lo
    function automatic int hi_w(input int w);
        return RADIX == 4 ? w + 2 : w;
    endfunction
    function automatic int lo_w(input int w);
        return RADIX == 4 ? w + 3 : w;
    endfunction
    function automatic booth_t booth_enc(input logic [2:0] bits);
        return bits == 3'b001 || bits == 3'b010 ? POS1 :
               bits == 3'b011 ? POS2 :
               bits == 3'b100 ? NEG2 :
               bits == 3'b101 || bits == 3'b110 ? NEG1 : ZERO;
    endfunction
endpackage

// File: rtl/seq_mul_step.sv
// seq_mul_step: one combinational shift-add step producing next {Hi,Lo}.
// SEQ_MULTIPLIER_RADIX4_EN swaps the radix-2 step for a Booth radix-4 step.
module seq_mul_step
    import seq_mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [hi_w(W)-1:0] hi,
    input  logic [lo_w(W)-1:0] lo,
    input  logic [W-1:0]       b,
    input  logic               sgn,
`ifndef SEQ_MULTIPLIER_RADIX4_EN
    input  logic               last_step,
`endif
    output logic [hi_w(W)-1:0] hi_next,
    output logic [lo_w(W)-1:0] lo_next
);
`ifdef SEQ_MULTIPLIER_RADIX4_EN
    logic [W+2:0] hx, bx, p;
    booth_t d;
    always_comb begin
        hx = {hi[W+1], hi};
        bx = {{3{sgn & b[W-1]}}, b};
        d = booth_enc(lo[2:0]);
        p = d == POS1 ? hx + bx :
            d == POS2 ? hx + {bx[W+1:0], 1'b0} :
            d == NEG1 ? hx - bx :
            d == NEG2 ? hx - {bx[W+1:0], 1'b0} : hx;
        hi_next = {p[W+2], p[W+2:2]};
        lo_next = {p[1:0], lo[W+2:2]};
    end
`else
    logic [W:0] hx, bx, p;
    always_comb begin
        hx = {sgn & hi[W-1], hi};
        bx = {sgn & b[W-1], b};
        // signed multiplier MSB carries weight -2^(W-1)
        p = !lo[0] ? hx : last_step && sgn ? hx - bx : hx + bx;
        hi_next = p[W:1];
        lo_next = {p[0], lo[W-1:1]};
    end
`endif
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential signed/unsigned multiplier with start/busy/done handshake.
// SEQ_MULTIPLIER_RADIX4_EN enables radix-4 Booth (W/2+1 steps).
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int W            = 32,
    parameter bit RESET_RESULT = 1
) (
    input  logic           CLK,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result
);
    localparam int N  = n_steps(W, RADIX);
    localparam int HW = hi_w(W);
    localparam int LW = lo_w(W);
    localparam int CW = $clog2(N);

    state_t state, state_n;
    logic [CW-1:0] count;
    logic [HW-1:0] hi, hi_n;
    logic [LW-1:0] lo, lo_n, lo_init;
    logic [W-1:0] b_q;
    logic sgn_q, last, accept;
    logic [2*W-1:0] product;

    assign last   = count == CW'(N - 1);
    assign accept = state == IDLE && start;
`ifdef SEQ_MULTIPLIER_RADIX4_EN
    assign lo_init = {{2{sgn & A[W-1]}}, A, 1'b0};
    assign product = {hi_n[W-3:0], lo_n[W+2:1]};
`else
    assign lo_init = A;
    assign product = {hi_n, lo_n};
`endif

    seq_mul_step #(.W(W)) u_step (
        .hi       (hi),
        .lo       (lo),
        .b        (b_q),
        .sgn      (sgn_q),
`ifndef SEQ_MULTIPLIER_RADIX4_EN
        .last_step(last),
`endif
        .hi_next  (hi_n),
        .lo_next  (lo_n)
    );

    always_comb begin
        busy    = state == RUN;
        done    = state == DONE;
        state_n = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge CLK or negedge rst)
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                count <= '0;
                hi    <= '0;
                lo    <= lo_init;
                b_q   <= B;
                sgn_q <= sgn;
            end else if (state == RUN) begin
                count <= count + CW'(1);
                hi    <= hi_n;
                lo    <= lo_n;
            end
        end

    generate
        if (RESET_RESULT) begin : g_rst
            always_ff @(posedge CLK or negedge rst)
                if (!rst) result <= '0;
                else if (state == RUN && last) result <= product;
        end else begin : g_nrst
            always_ff @(posedge CLK)
                if (state == RUN && last) result <= product;
        end
    endgenerate
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: table-driven and scoreboard checks of seq_multiplier at W=32 and W=8.
// Honours SEQ_MULTIPLIER_RADIX4_EN for the expected latency.
module tb_seq_multiplier;
`ifdef SEQ_MULTIPLIER_RADIX4_EN
    localparam int N32 = 17;
    localparam int N8  = 5;
`else
    localparam int N32 = 32;
    localparam int N8  = 8;
`endif

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    logic CLK = 1'b0;
    logic rst;
    logic start32, sgn32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic start8, sgn8, busy8, done8;
    logic [7:0] a8, b8;
    logic [15:0] res8;
    int checks = 0;
    int failures = 0;
    logic [63:0] q32[$];
    logic [15:0] q8[$];
    longint t_prev;
    bit have_prev;

    always #5 CLK = ~CLK;

    seq_multiplier #(.W(32)) dut32 (
        .CLK(CLK), .rst(rst), .start(start32), .sgn(sgn32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .result(res32)
    );

    seq_multiplier #(.W(8)) dut8 (
        .CLK(CLK), .rst(rst), .start(start8), .sgn(sgn8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .result(res8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y;
        x = s ? {{32{a[31]}}, a} : {32'b0, a};
        y = s ? {{32{b[31]}}, b} : {32'b0, b};
        return x * y;
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] x, y;
        x = s ? {{8{a[7]}}, a} : {8'b0, a};
        y = s ? {{8{b[7]}}, b} : {8'b0, b};
        return x * y;
    endfunction

    // scoreboards: every done pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (done32) begin
            if (q32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done32_unexpected: got done=1 expected no pending op");
            end else chk("result32", res32, q32.pop_front());
        end
        if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done8_unexpected: got done=1 expected no pending op");
            end else chk("result8", 64'(res8), 64'(q8.pop_front()));
        end
    end

    task automatic wait32(output int cyc, output int bc);
        cyc = 1;
        bc = 0;
        while (!done32 && cyc < 100) begin
            if (busy32) bc++;
            @(posedge CLK); #1;
            cyc++;
        end
        chk("done32_seen", 64'(done32), 64'd1);
        chk("latency32", 64'(cyc), 64'(N32 + 1));
        chk("busy32_cycles", 64'(bc), 64'(N32));
    endtask

    task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int cyc, bc;
        @(negedge CLK);
        start32 = 1'b1; sgn32 = s; a32 = a; b32 = b;
        q32.push_back(exp);
        @(posedge CLK); #1;
        start32 = 1'b0;
        wait32(cyc, bc);
        @(posedge CLK); #1;
        chk("done32_pulse", {62'b0, busy32, done32}, 64'd0);
    endtask

    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int cyc;
        @(negedge CLK);
        start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
        q8.push_back(ref8(s, a, b));
        @(posedge CLK); #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b;
        cyc = 1;
        while (!done8 && cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("done8_seen", 64'(done8), 64'd1);
        if (have_prev) chk("period8", 64'($time - t_prev), 64'((N8 + 2) * 10));
        t_prev = $time;
        have_prev = 1'b1;
        @(posedge CLK); #1;
        chk("done8_pulse", {62'b0, busy8, done8}, 64'd0);
    endtask

    vec_t tbl[7];
    logic [7:0] cv[8];

    initial begin
        int cyc, bc;
        tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        tbl[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB};
        tbl[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
        tbl[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
        tbl[4] = '{1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000};
        tbl[5] = '{1'b0, 32'h00000000, 32'h00000000, 64'h0000000000000000};
        tbl[6] = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000};
        cv = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
        have_prev = 1'b0;
        t_prev = 0;
        rst = 1'b0;
        start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset32", {busy32, done32, res32[61:0]}, 64'd0);
        chk("reset8", {46'b0, busy8, done8, res8}, 64'd0);
        @(negedge CLK);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) op32(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp);
        for (int i = 0; i < 4; i++) begin
            logic s;
            logic [31:0] a, b;
            s = 1'(i);
            a = $urandom;
            b = $urandom;
            op32(s, a, b, ref32(s, a, b));
        end

        // restart mid-RUN and operand churn must not disturb the accepted op
        @(negedge CLK);
        start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd6; b32 = 32'd7;
        q32.push_back(64'd42);
        @(posedge CLK); #1;
        start32 = 1'b0;
        a32 = 32'hDEADBEEF; b32 = 32'h12345678; sgn32 = 1'b1;
        cyc = 1;
        repeat (3) begin
            @(posedge CLK); #1;
            cyc++;
        end
        start32 = 1'b1; a32 = 32'd100; b32 = 32'd200;
        while (!done32 && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("restart_done_seen", 64'(done32), 64'd1);
        chk("restart_latency", 64'(cyc), 64'(N32 + 1));
        start32 = 1'b0;
        @(posedge CLK); #1;
        chk("start_in_done_ignored", {62'b0, busy32, done32}, 64'd0);

        // asynchronous reset in the middle of RUN aborts without a done pulse
        @(negedge CLK);
        start32 = 1'b1; sgn32 = 1'b1; a32 = 32'h12345678; b32 = 32'h9ABCDEF0;
        @(posedge CLK); #1;
        start32 = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        chk("busy_before_reset", 64'(busy32), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_reset32", {busy32, done32, res32[61:0]}, 64'd0);
        @(negedge CLK);
        rst = 1'b1;
        op32(1'b0, 32'h00012345, 32'h00000010, 64'h0000000000123450);

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++) op8(1'(s), cv[i], cv[j]);
        for (int k = 0; k < 1200; k++) op8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
